// File: rtl/wb_port_arbiter_if.sv
// Write-back arbiter bus: pipeline and long-latency sources in,
// single register file write port and hazard checks out.
interface wb_port_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic              stall_req;
  logic              we;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] chk1_addr;
  logic              chk1_pending;
  logic [ADDR_W-1:0] chk2_addr;
  logic              chk2_pending;
  logic [CW-1:0]     fifo_count;

  modport slave (
    input  pipe_we, pipe_addr, pipe_data,
    input  lu_valid, lu_addr, lu_data,
    input  chk1_addr, chk2_addr,
    output lu_ready, stall_req,
    output we, write_addr, write_data,
    output chk1_pending, chk2_pending,
    output fifo_count
  );

  modport master (
    output pipe_we, pipe_addr, pipe_data,
    output lu_valid, lu_addr, lu_data,
    output chk1_addr, chk2_addr,
    input  lu_ready, stall_req,
    input  we, write_addr, write_data,
    input  chk1_pending, chk2_pending,
    input  fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by the in-order pipeline
// and a FIFO of long-latency results, with starvation relief.
module wb_port_arbiter #(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     starve;
  logic              stall_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic          empty;
  logic          pipe_req;
  logic          accept;
  logic          push;
  logic          pop;
  logic          take_pipe;
  logic [SW-1:0] starve_nxt;
  logic          hit1;
  logic          hit2;

  assign empty      = cnt == '0;
  assign pipe_req   = bus.pipe_we && (bus.pipe_addr != '0);
  assign bus.lu_ready = cnt < CW'(DEPTH);
  assign accept     = bus.lu_valid && bus.lu_ready;
  assign push       = accept && (bus.lu_addr != '0);
  assign starve_nxt = starve + 1'b1;

  always_comb begin
    pop       = 1'b0;
    take_pipe = 1'b0;
    priority case (1'b1)
      stall_q:  pop       = !empty;
      pipe_req: take_pipe = 1'b1;
      !empty:   pop       = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wptr] <= bus.lu_addr;
      mem_data[wptr] <= bus.lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      starve  <= '0;
      stall_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt  <= cnt + CW'(push) - CW'(pop);
      we_q <= pop || take_pipe;
      if (pop) begin
        addr_q <= mem_addr[rptr];
        data_q <= mem_data[rptr];
      end else if (take_pipe) begin
        addr_q <= bus.pipe_addr;
        data_q <= bus.pipe_data;
      end
      // stall_req is a one-cycle pulse: the forced pop clears it
      if (pop || empty) begin
        starve  <= '0;
        stall_q <= 1'b0;
      end else if (take_pipe) begin
        starve  <= starve_nxt;
        stall_q <= starve_nxt == SW'(STARVE_MAX);
      end
    end
  end

  always_comb begin
    logic [PW-1:0] off;
    logic          live;
    hit1 = 1'b0;
    hit2 = 1'b0;
    off  = '0;
    live = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off  = PW'(i) - rptr;
      live = CW'(off) < cnt;
      if (live && mem_addr[i] == bus.chk1_addr) hit1 = 1'b1;
      if (live && mem_addr[i] == bus.chk2_addr) hit2 = 1'b1;
    end
  end

  assign bus.chk1_pending = hit1 && (bus.chk1_addr != '0);
  assign bus.chk2_pending = hit2 && (bus.chk2_addr != '0);
  assign bus.stall_req    = stall_q;
  assign bus.we           = we_q;
  assign bus.write_addr   = addr_q;
  assign bus.write_data   = data_q;
  assign bus.fifo_count   = cnt;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed stimulus, expected writes
// queued up front and checked by an independent write monitor.
module tb_wb_port_arbiter;
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus ();

  wb_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t sb[$];
  int  tests = 0;
  int  fails = 0;

  function automatic wr_t w(input logic [4:0] a, input logic [31:0] d);
    wr_t r;
    r.addr = a;
    r.data = d;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%h expected none",
                 bus.write_addr, bus.write_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (bus.write_addr !== e.addr || bus.write_data !== e.data) begin
          fails++;
          $display("FAIL write_port: got addr=%0d data=%h expected addr=%0d data=%h",
                   bus.write_addr, bus.write_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic rdy;
    logic st;
    int   acc;
    int   waited;
    int   issued;

    bus.pipe_we   = 1'b1;
    bus.pipe_addr = 5'd3;
    bus.pipe_data = 32'h0;
    bus.lu_valid  = 1'b1;
    bus.lu_addr   = 5'd2;
    bus.lu_data   = 32'h22;
    bus.chk1_addr = 5'd0;
    bus.chk2_addr = 5'd0;
    rst = 1'b0;

    // reset held two edges with requests asserted
    step();
    step();
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_lu_ready", 32'(bus.lu_ready), 32'd1);
    check("rst_stall", 32'(bus.stall_req), 32'd0);

    rst = 1'b1;
    bus.lu_valid  = 1'b0;
    bus.pipe_data = 32'hA5A5A5A5;
    sb.push_back(w(5'd3, 32'hA5A5A5A5));
    step();
    check("pipe_we", 32'(bus.we), 32'd1);
    check("pipe_addr", 32'(bus.write_addr), 32'd3);
    bus.pipe_we = 1'b0;
    step();

    // long-latency only
    sb.push_back(w(5'd7, 32'h11));
    bus.lu_valid  = 1'b1;
    bus.lu_addr   = 5'd7;
    bus.lu_data   = 32'h11;
    bus.chk1_addr = 5'd7;
    check("pend_before", 32'(bus.chk1_pending), 32'd0);
    step();
    bus.lu_valid = 1'b0;
    check("lu_count1", 32'(bus.fifo_count), 32'd1);
    check("pend_queued", 32'(bus.chk1_pending), 32'd1);
    step();
    check("pend_written", 32'(bus.chk1_pending), 32'd0);
    check("lu_we", 32'(bus.we), 32'd1);
    check("lu_addr", 32'(bus.write_addr), 32'd7);
    bus.chk1_addr = 5'd0;
    step();

    // fill FIFO while pipe writes every cycle
    for (int k = 1; k <= 4; k++) sb.push_back(w(5'(20 + k), 32'h100 + k));
    for (int k = 1; k <= 5; k++) sb.push_back(w(5'(k), 32'h200 + k));
    for (int k = 1; k <= 4; k++) begin
      bus.pipe_we   = 1'b1;
      bus.pipe_addr = 5'(20 + k);
      bus.pipe_data = 32'h100 + k;
      bus.lu_valid  = 1'b1;
      bus.lu_addr   = 5'(k);
      bus.lu_data   = 32'h200 + k;
      step();
    end
    bus.pipe_we = 1'b0;
    bus.lu_addr = 5'd5;
    bus.lu_data = 32'h205;
    check("full_ready", 32'(bus.lu_ready), 32'd0);
    check("full_count", 32'(bus.fifo_count), 32'd4);
    check("full_stall", 32'(bus.stall_req), 32'd1);
    acc = 0;
    waited = 0;
    for (int c = 0; c < 10 && acc == 0; c++) begin
      rdy = bus.lu_ready;
      step();
      waited++;
      if (rdy) acc = 1;
    end
    bus.lu_valid = 1'b0;
    check("lu5_accept", 32'(acc), 32'd1);
    check("lu5_wait", 32'(waited), 32'd2);
    check("lu5_count", 32'(bus.fifo_count), 32'd3);
    repeat (4) step();

    // starvation with held pipe request
    for (int k = 0; k < 4; k++) sb.push_back(w(5'd5, 32'h1000 + k));
    sb.push_back(w(5'd9, 32'h99));
    sb.push_back(w(5'd5, 32'h1004));
    sb.push_back(w(5'd5, 32'h1005));
    bus.pipe_we   = 1'b1;
    bus.pipe_addr = 5'd5;
    bus.pipe_data = 32'h1000;
    bus.lu_valid  = 1'b1;
    bus.lu_addr   = 5'd9;
    bus.lu_data   = 32'h99;
    issued = 0;
    for (int i = 0; i < 8; i++) begin
      st = bus.stall_req;
      step();
      if (i == 0) bus.lu_valid = 1'b0;
      if (!st && bus.pipe_we) begin
        issued++;
        if (issued == 6) bus.pipe_we = 1'b0;
        else bus.pipe_data = 32'h1000 + 32'(issued);
      end
      if (i == 3) check("starve_stall_on", 32'(bus.stall_req), 32'd1);
      if (i == 4) check("starve_stall_off", 32'(bus.stall_req), 32'd0);
    end

    // r0 handling
    sb.push_back(w(5'd6, 32'h66));
    bus.pipe_we   = 1'b1;
    bus.pipe_addr = 5'd0;
    bus.pipe_data = 32'hDEAD;
    bus.lu_valid  = 1'b1;
    bus.lu_addr   = 5'd6;
    bus.lu_data   = 32'h66;
    bus.chk1_addr = 5'd0;
    bus.chk2_addr = 5'd6;
    step();
    bus.lu_valid = 1'b0;
    check("r0_count", 32'(bus.fifo_count), 32'd1);
    check("r0_pend2", 32'(bus.chk2_pending), 32'd1);
    check("r0_pend1", 32'(bus.chk1_pending), 32'd0);
    step();
    check("r0_pop_we", 32'(bus.we), 32'd1);
    check("r0_pop_addr", 32'(bus.write_addr), 32'd6);
    bus.pipe_we  = 1'b0;
    bus.lu_valid = 1'b1;
    bus.lu_addr  = 5'd0;
    bus.lu_data  = 32'h77;
    step();
    bus.lu_valid = 1'b0;
    check("r0_push_count", 32'(bus.fifo_count), 32'd0);
    step();
    check("r0_push_we", 32'(bus.we), 32'd0);
    bus.chk2_addr = 5'd0;

    // reset mid-operation drops queued entries
    for (int k = 1; k <= 3; k++) sb.push_back(w(5'(k), 32'h600 + k));
    for (int k = 1; k <= 3; k++) begin
      bus.pipe_we   = 1'b1;
      bus.pipe_addr = 5'(k);
      bus.pipe_data = 32'h600 + k;
      bus.lu_valid  = 1'b1;
      bus.lu_addr   = 5'(10 + k);
      bus.lu_data   = 32'h700 + k;
      step();
    end
    bus.pipe_we  = 1'b0;
    bus.lu_valid = 1'b0;
    check("mid_count", 32'(bus.fifo_count), 32'd3);
    rst = 1'b0;
    step();
    check("mid_rst_count", 32'(bus.fifo_count), 32'd0);
    check("mid_rst_we", 32'(bus.we), 32'd0);
    check("mid_rst_ready", 32'(bus.lu_ready), 32'd1);
    rst = 1'b1;
    repeat (6) step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Single-write-port arbiter in front of the 32-entry register file.
- Merges two write-back sources into one registered write port (we/write_addr/write_data):
  - in-order pipeline results;
  - a long-latency unit (load/mul/div) via valid/ready handshake and a small in-order FIFO.
- Reports whether a register has a write still queued, so decode can stall on RAW hazards that the register file's same-cycle write forwarding cannot cover.

Parameters:
- DEPTH, 4, long-latency FIFO entries; power of 2, at least 2.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- STARVE_MAX, 3, consecutive cycles the FIFO may lose arbitration before it is forced to win.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-low (rst==0 resets at the next rising edge)
- pipe_we  in  1  pipeline write request
- pipe_addr  in  ADDR_W  pipeline destination register
- pipe_data  in  DATA_W  pipeline result
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept
- lu_addr  in  ADDR_W  long-latency destination register
- lu_data  in  DATA_W  long-latency result
- stall_req  out  1  pipeline must hold pipe_we/pipe_addr/pipe_data stable
- we  out  1  register file write enable
- write_addr  out  ADDR_W  register file write address
- write_data  out  DATA_W  register file write data
- chk1_addr  in  ADDR_W  decode read-port-1 address to check
- chk1_pending  out  1  a queued FIFO write targets chk1_addr
- chk2_addr  in  ADDR_W  decode read-port-2 address to check
- chk2_pending  out  1  a queued FIFO write targets chk2_addr
- fifo_count  out  log2(DEPTH)+1  queued entries

Behaviour:
- Reset state: we=0, write_addr=0, write_data=0, FIFO empty, fifo_count=0, starve counter=0, stall_req=0.
- Reset mid-operation flushes queued entries; they are lost.
- pipe_req = pipe_we && pipe_addr!=0. A pipe write to r0 is a no-request and leaves the slot free for the FIFO.
- Arbitration, evaluated each cycle:
  - If stall_req=1: pop FIFO head. Pipe is not consumed; upstream holds it.
  - Else if pipe_req: issue pipe.
  - Else if FIFO non-empty: pop head.
  - Else no write.
- Write port is registered. The chosen write appears on we/write_addr/write_data in the cycle after the arbitration edge. With no write, we=0 and addr/data hold their previous values.
- Pipe latency: pipe_req sampled at edge E gives we=1 after edge E.
- Long-latency latency:
  - Accept at edge E0 when lu_valid && lu_ready.
  - Earliest pop at edge E0+1, so we=1 after E0+1.
  - No bypass around the FIFO.
- lu_ready = (fifo_count < DEPTH), from registered count only.
  - When full, lu_ready=0 even in a cycle that pops.
  - Simultaneous push and pop when not full: count unchanged.
- Accepted lu entries with lu_addr==0 are consumed and discarded; no push, no write.
- FIFO order is strict: pops occur in push order. Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Starvation:
  - Counter increments on each edge where FIFO is non-empty and the pipe wins.
  - Counter clears on any FIFO pop, or whenever the FIFO is empty.
  - stall_req is registered: it goes to 1 on the edge where the counter reaches STARVE_MAX.
  - It stays 1 for exactly one cycle (one forced pop), then clears along with the counter.
  - A pipe_req present while stall_req=1 is written on a following cycle, with no loss and no duplication.
- chkN_pending (combinational) = chkN_addr!=0 and some valid FIFO entry has addr==chkN_addr.
  - The entry currently on the output port is not counted; the register file forwards it.
- WAW ordering between the pipe and FIFO sources is upstream's responsibility (decode stalls on pending). This block does not reorder or compare across sources.

Test Plan:
- Reset: hold rst=0 for 2 edges with pipe_we=1 and lu_valid=1 → we=0, fifo_count=0, lu_ready=1, stall_req=0. Release, drive pipe_we=1, pipe_addr=3, pipe_data=0xA5A5A5A5 → next cycle we=1, write_addr=3, write_data=0xA5A5A5A5.
- Long-latency only: push lu_addr=7/data=0x11 at edge E0, pipe idle → we=1, addr=7, data=0x11 after E0+1. chk1_addr=7 gives chk1_pending=1 during cycle E0..E0+1, 0 afterwards.
- Full FIFO: push 4 entries (addrs 1..4) while the pipe writes every cycle → lu_ready=0 and fifo_count=4. A 5th lu_valid is held and accepted only after the first pop. Writes emerge in order 1,2,3,4,5.
- Starvation: FIFO holds addr 9, pipe_req every cycle (addr 5, data incrementing) → after 3 pipe wins stall_req=1 for one cycle and addr 9 is written. The held pipe value is written next, with no gap or duplicate.
- r0 handling: pipe_we=1 with pipe_addr=0 while the FIFO holds addr 6 → FIFO pops (write to 6). lu push with addr 0 → fifo_count unchanged, no write. chk1_addr=0 → chk1_pending=0.
- Reset mid-operation: 3 entries queued, assert rst=0 one edge → fifo_count=0, we=0 next cycle, queued entries never written.
